operand_bypass_ctrl: RTL

//  Parametrised bypass/hazard controller for the pipelined datapath; generates the ALU operand mux selects.

---
 rtl/bypass_pkg.sv | 14 +
 rtl/bypass_match.sv | 33 +++
 rtl/operand_bypass_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/bypass_pkg.sv
// Shared types for the operand bypass controller: scoreboard entry layout and
// the fwd_sel encoding that selects the register file.
package bypass_pkg;

  localparam int unsigned SB_REG_W    = 5;
  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
    logic                load;
  } sb_entry_t;

endpackage

// File: rtl/bypass_match.sv
// Per-channel bypass match: picks the youngest valid scoreboard entry whose
// destination equals the source register and flags a load-use hazard.
module bypass_match
  import bypass_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = 2
) (
  input  sb_entry_t [DEPTH-1:0] i_entries,
  input  logic [SB_REG_W-1:0]   i_src,
  output logic [SEL_W-1:0]      o_fwd_sel,
  output logic                  o_stall
);

  logic w_found;

  // Priority encoder from entry 0 upward; $zero never matches.
  always_comb begin
    o_fwd_sel = SEL_W'(FWD_REGFILE);
    o_stall   = 1'b0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!w_found && (i_src != '0) && i_entries[k].valid &&
          (i_entries[k].rd == i_src)) begin
        w_found   = 1'b1;
        o_fwd_sel = SEL_W'(k + 1);
        o_stall   = (k < LOAD_LAT) && i_entries[k].load;
      end
    end
  end

endmodule

// File: rtl/operand_bypass_ctrl.sv
// Bypass/hazard controller: in-flight writer scoreboard, per-channel operand
// selects and load-use stall. Optional counters under BYPASS_STATS_EN.
module operand_bypass_ctrl
  import bypass_pkg::*;
#(
  parameter int unsigned REG_W    = SB_REG_W,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    advance,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic                    issue_wen,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic                    issue_load,
  input  logic [NSRC*REG_W-1:0]   src_reg,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
`ifdef BYPASS_STATS_EN
  output logic [31:0]             stall_cnt,
  output logic [31:0]             fwd_cnt,
`endif
  output logic                    stall
);

  sb_entry_t [DEPTH-1:0] r_sb;
  sb_entry_t [DEPTH-1:0] w_sb_nxt;
  sb_entry_t             w_issue;
  logic [NSRC-1:0]       w_stall_vec;

  // Non-writers, $zero writers, stalled or flushed issues enter as bubbles.
  always_comb begin
    w_issue = '0;
    if (issue_valid && issue_wen && (issue_rd != '0) && !stall && !flush) begin
      w_issue.valid = 1'b1;
      w_issue.rd    = issue_rd;
      w_issue.load  = issue_load;
    end
  end

  always_comb begin
    w_sb_nxt = r_sb;
    if (advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        w_sb_nxt[k] = r_sb[k-1];
      end
      w_sb_nxt[0] = w_issue;
    end else if (flush) begin
      w_sb_nxt[0] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  for (genvar c = 0; c < NSRC; c++) begin : g_ch
    bypass_match #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .i_entries (r_sb),
      .i_src     (src_reg[c*REG_W +: REG_W]),
      .o_fwd_sel (fwd_sel[c*SEL_W +: SEL_W]),
      .o_stall   (w_stall_vec[c])
    );
  end

  assign stall = |w_stall_vec;

`ifdef BYPASS_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_fwd_any;

  assign w_fwd_any = |fwd_sel;

  // Free-running wrap-around counters of stalled and forwarding advances.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (stall && advance) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_fwd_any && advance && !stall) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  // Statistics disabled: no counter state.
`endif

endmodule
